// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at issue and committed when the busy countdown expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_MD_I,
  input  logic [2:0]  Op_MD_I,
  input  logic [31:0] A_MD_I,
  input  logic [31:0] B_MD_I,
  output logic [31:0] HI_MD_O,
  output logic [31:0] LO_MD_O,
  output logic        Busy_MD_O
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        busy;
  logic [31:0] hi, lo, pend_hi, pend_lo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;
  logic [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{A_MD_I[31]}}, A_MD_I}) * $signed({{32{B_MD_I[31]}}, B_MD_I});
  assign prod_u = {32'd0, A_MD_I} * {32'd0, B_MD_I};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign b_zero = (B_MD_I == 32'd0);
  assign a_mag  = A_MD_I[31] ? (32'd0 - A_MD_I) : A_MD_I;
  assign b_mag  = B_MD_I[31] ? (32'd0 - B_MD_I) : B_MD_I;
  assign b_safe = b_zero ? 32'd1 : B_MD_I;
  assign q_mag  = a_mag / (b_zero ? 32'd1 : b_mag);
  assign r_mag  = a_mag % (b_zero ? 32'd1 : b_mag);
  assign q_s    = (A_MD_I[31] ^ B_MD_I[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s    = A_MD_I[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u    = A_MD_I / b_safe;
  assign r_u    = A_MD_I % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (Op_MD_I)
      3'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      3'd2: begin
        res_hi = b_zero ? A_MD_I : r_s;
        res_lo = b_zero ? 32'hFFFF_FFFF : q_s;
      end
      3'd3: begin
        res_hi = b_zero ? A_MD_I : r_u;
        res_lo = b_zero ? 32'hFFFF_FFFF : q_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start_MD_I) begin
            case (Op_MD_I)
              3'd0, 3'd1: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= 4'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd2, 3'd3: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= 4'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'd4: hi <= A_MD_I;
              3'd5: lo <= A_MD_I;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Starts arriving while running are dropped; the hazard unit should prevent them.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HI_MD_O   = hi;
  assign LO_MD_O   = lo;
  assign Busy_MD_O = busy;

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start_MD_I(start), .Op_MD_I(op),
    .A_MD_I(a), .B_MD_I(b), .HI_MD_O(hi), .LO_MD_O(lo), .Busy_MD_O(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic from the instruction definitions.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, q, r, p;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    rh = m_hi;
    rl = m_lo;
    case (o)
      3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; rh = r[31:0]; rl = q[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin up = ux / uy; rh = 32'(ux % uy); rl = up[31:0]; end
      end
      3'd4: rh = x;
      3'd5: rl = x;
      default: ;
    endcase
  endtask

  // Issue now (called #1 after an edge), then follow the op to completion.
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int n;
    model(o, x, y, eh, el);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    if (o <= 3'd3) begin
      n = (o <= 3'd1) ? MC : DC;
      chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      repeat (n - 1) begin
        @(posedge clk); #1;
        chk({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hi_hold"}, hi, m_hi);
        chk({tag, "_lo_hold"}, lo, m_lo);
      end
      @(posedge clk); #1;
    end
    m_hi = eh; m_lo = el;
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFFA);
    issue("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", lo, 32'h0000_0001);
    issue("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);
    issue("divu_zero", 3'd3, 32'd7, 32'd0);
    chk("divu_zero_lo_const", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi_const", hi, 32'd7);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    chk("div_ovf_hi_const", hi, 32'd0);
    issue("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0);
    issue("mthi", 3'd4, 32'h1234_5678, 32'd0);
    issue("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mt_hi_const", hi, 32'h1234_5678);
    issue("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1);

    // Starts during busy must be ignored.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    chk("ign_busy_rise", {31'd0, busy}, 32'd1);
    for (int k = 1; k < DC; k++) begin
      if (k == 3) begin start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; end
      if (k == 6) begin start = 1'b1; op = 3'd4; a = 32'hDEAD_0000; end
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7;
      chk("ign_busy_hold", {31'd0, busy}, 32'd1);
      chk("ign_hi_hold", hi, m_hi);
    end
    @(posedge clk); #1;
    m_hi = 32'd2; m_lo = 32'd14;
    chk("ign_busy_end", {31'd0, busy}, 32'd0);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    issue("b2b_mult", 3'd0, 32'd3, 32'd5);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #2 reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (DC + 5) @(posedge clk);
    #1;
    chk("arst_late_hi", hi, 32'd0);
    chk("arst_late_lo", lo, 32'd0);
    chk("arst_late_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      issue("rand", ro, ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rand_idle_hi", hi, m_hi);
        chk("rand_idle_lo", lo, m_lo);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
